instr_fetch_ctrl: RTL
=====================

INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- RESET_PC, 8'h00, PC value loaded at reset.
- HALT_OP, 4'b0000, opcode in bits [15:12] that marks a halt instruction.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, input, 1, sole clock; all state updates on its rising edge.
- rst, input, 1, asynchronous, active-high reset.
- start, input, 1, one-cycle pulse to begin or restart fetching.
- start_pc, input, 8, PC captured on an accepted start.
- rom_addr, output, 8, address to the combinational instruction ROM.
- rom_data, input, 16, ROM word for rom_addr, valid in the same cycle.
- ir, output, 16, instruction register.
- ir_pc, output, 8, address ir was fetched from.
- ir_valid, output, 1, ir holds an unconsumed instruction.
- ir_ready, input, 1, decode accepts ir when ir_valid && ir_ready.
- br_taken, input, 1, redirect request from execute.
- br_target, input, 8, redirect address.
- halted, output, 1, controller is in HALT.
- busy, output, 1, controller is in RUN.
- fetch_cnt, output, 16, instructions loaded into ir since last start.

Function
REQ-003 The controller SHALL have 3 states (IDLE, RUN, HALT) and an 8-bit register pc.
REQ-004 rom_addr SHALL equal pc combinationally in every state.
REQ-005 A fetch SHALL occur in RUN when !br_taken && (!ir_valid || ir_ready):
- ir <= rom_data, ir_pc <= pc, ir_valid <= 1, fetch_cnt increments.
- Fetch-to-ir latency is 1 cycle.
- Back-to-back fetches give 1 instruction per cycle while ir_ready=1.
REQ-006 On a fetch where rom_data[15:12] != HALT_OP, pc SHALL become pc+1 modulo 256 (8'hFF wraps to 8'h00, no flag).
REQ-007 On a fetch where rom_data[15:12] == HALT_OP:
- The halt word SHALL still be loaded into ir with ir_valid=1.
- pc SHALL be held.
- State SHALL go to HALT.
REQ-008 In RUN with ir_valid && !ir_ready and no br_taken, ir, ir_pc, ir_valid, pc and fetch_cnt SHALL hold (stall).
REQ-009 br_taken in RUN SHALL flush and redirect:
- ir_valid <= 0 and pc <= br_target.
- No fetch occurs that cycle.
- br_taken has priority over a simultaneous fetch or ir_ready handshake.
- The first fetch from br_target occurs the next cycle.
REQ-010 br_taken SHALL be ignored in IDLE and HALT.
REQ-011 start in IDLE or HALT SHALL:
- set pc <= start_pc, ir_valid <= 0, fetch_cnt <= 0;
- move the state to RUN.
REQ-012 start in RUN SHALL be ignored.
REQ-013 In HALT, no fetch SHALL occur; ir_valid SHALL clear on the cycle it is consumed (ir_ready=1) and otherwise hold.
REQ-014 fetch_cnt SHALL saturate at 16'hFFFF.
REQ-015 halted SHALL equal (state==HALT) and busy SHALL equal (state==RUN), both registered-state decodes with no extra latency.

Reset
REQ-016 While rst=1, regardless of clk, the block SHALL force:
- state=IDLE, pc=RESET_PC, ir=16'h0000, ir_pc=8'h00;
- ir_valid=0, fetch_cnt=16'h0000, halted=0, busy=0.
REQ-017 Reset asserted mid-fetch or mid-stall SHALL discard the in-flight instruction; after deassertion the block SHALL stay in IDLE until start.

Verification
REQ-018 The bench SHALL cover these directed scenarios (stimulus -> required response):
1. Sequential run to halt:
   - Stimulus: ROM [00]=16'h7017, [01]=16'h8122, [02]=16'h0000; start with start_pc=8'h00; ir_ready=1.
   - Response: ir = 7017 (ir_pc 00), 8122 (01), 0000 (02) on consecutive cycles; then halted=1, pc=8'h02, fetch_cnt=3.
2. Stall:
   - Stimulus: ir_ready=0 for 3 cycles after the first fetch.
   - Response: ir=16'h7017, pc=8'h01 and fetch_cnt=1 hold; fetching resumes the cycle after ir_ready=1.
3. Branch with simultaneous handshake:
   - Stimulus: br_taken=1, br_target=8'h0C while ir_valid=1 and ir_ready=1.
   - Response: next cycle ir_valid=0, pc=8'h0C; the cycle after, ir_pc=8'h0C.
4. Wrap:
   - Stimulus: start_pc=8'hFF, ROM[FF]=16'h1124.
   - Response: ir_pc=8'hFF, pc=8'h00 after the fetch.
5. Restart and ignore rules:
   - Stimulus: start with start_pc=8'h05 while in HALT.
   - Response: busy=1, fetch_cnt=0, first ir_pc=8'h05.
   - Stimulus: start pulse while in RUN.
   - Response: no effect.
6. Async reset:
   - Stimulus: rst asserted between clock edges during RUN.
   - Response: ir_valid=0, pc=8'h00, busy=0 immediately; the block stays in IDLE until start.

Source files
------------

// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: single-issue fetch controller feeding an instruction register from a combinational ROM.
module instr_fetch_ctrl #(
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter logic [3:0] HALT_OP  = 4'b0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  start_pc,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic [15:0] ir,
    output logic [7:0]  ir_pc,
    output logic        ir_valid,
    input  logic        ir_ready,
    input  logic        br_taken,
    input  logic [7:0]  br_target,
    output logic        halted,
    output logic        busy,
    output logic [15:0] fetch_cnt
);
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
    state_t state, state_n;
    logic [7:0] pc, pc_n, ir_pc_n;
    logic [15:0] ir_n, cnt_n;
    logic ir_valid_n, fetch;
    assign rom_addr = pc;
    assign halted = state == HALT;
    assign busy = state == RUN;
    assign fetch = state == RUN && !br_taken && (!ir_valid || ir_ready);
    always_comb begin
        state_n = state;
        pc_n = pc;
        ir_n = ir;
        ir_pc_n = ir_pc;
        ir_valid_n = ir_valid;
        cnt_n = fetch_cnt;
        if (state != RUN && start) begin
            state_n = RUN;
            pc_n = start_pc;
            ir_valid_n = 1'b0;
            cnt_n = 16'h0000;
        end else if (state == RUN && br_taken) begin
            ir_valid_n = 1'b0;
            pc_n = br_target;
        end else if (fetch) begin
            ir_n = rom_data;
            ir_pc_n = pc;
            ir_valid_n = 1'b1;
            cnt_n = (fetch_cnt == 16'hFFFF) ? fetch_cnt : fetch_cnt + 16'd1;
            // a halt word is delivered but pc parks on it
            state_n = (rom_data[15:12] == HALT_OP) ? HALT : RUN;
            pc_n = (rom_data[15:12] == HALT_OP) ? pc : pc + 8'd1;
        end else if (state == HALT && ir_ready) begin
            ir_valid_n = 1'b0;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            pc <= RESET_PC;
            ir <= 16'h0000;
            ir_pc <= 8'h00;
            ir_valid <= 1'b0;
            fetch_cnt <= 16'h0000;
        end else begin
            state <= state_n;
            pc <= pc_n;
            ir <= ir_n;
            ir_pc <= ir_pc_n;
            ir_valid <= ir_valid_n;
            fetch_cnt <= cnt_n;
        end
    end
endmodule
